// File: rtl/div_radix2.sv
// Radix-2 restoring divider for MIPS DIV/DIVU: 32 iterations, one quotient bit per cycle.
// result = {remainder (HI), quotient (LO)}, with signed correction applied on the final iteration.
module div_radix2 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [63:0] result
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_reg;
  logic [31:0] rem_reg;
  logic [31:0] quo_reg;
  logic [31:0] bmag_reg;
  logic [31:0] aorig_reg;
  logic [4:0]  count_reg;
  logic        signed_reg;
  logic        sign_a_reg;
  logic        sign_b_reg;
  logic        bzero_reg;

  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic [31:0] rem_next;
  logic [31:0] quo_next;
  logic [31:0] rem_fix;
  logic [31:0] quo_fix;
  logic [63:0] result_next;

  // Magnitudes of the incoming operands; negating 0x80000000 yields itself, which is the
  // correct unsigned magnitude.
  always_comb begin
    a_mag = (signed_div && a[31]) ? (32'd0 - a) : a;
    b_mag = (signed_div && b[31]) ? (32'd0 - b) : b;
  end

  // One restoring step on the shifted {rem, quo} pair.
  always_comb begin
    rem_sh = {rem_reg, quo_reg[31]};
    diff   = rem_sh - {1'b0, bmag_reg};
    if (!diff[32]) begin
      rem_next = diff[31:0];
      quo_next = {quo_reg[30:0], 1'b1};
    end else begin
      rem_next = rem_sh[31:0];
      quo_next = {quo_reg[30:0], 1'b0};
    end
  end

  // Sign fix-up on the last iteration's outputs, so result is already valid in the DONE cycle.
  always_comb begin
    quo_fix = (signed_reg && (sign_a_reg != sign_b_reg)) ? (32'd0 - quo_next) : quo_next;
    rem_fix = (signed_reg && sign_a_reg) ? (32'd0 - rem_next) : rem_next;
    if (bzero_reg) begin
      result_next = {aorig_reg, 32'hFFFF_FFFF};
    end else begin
      result_next = {rem_fix, quo_fix};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= 64'd0;
      rem_reg    <= 32'd0;
      quo_reg    <= 32'd0;
      bmag_reg   <= 32'd0;
      aorig_reg  <= 32'd0;
      count_reg  <= 5'd0;
      signed_reg <= 1'b0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      bzero_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start && !cancel) begin
            state_reg  <= RUN;
            busy       <= 1'b1;
            rem_reg    <= 32'd0;
            quo_reg    <= a_mag;
            bmag_reg   <= b_mag;
            aorig_reg  <= a;
            count_reg  <= 5'd0;
            signed_reg <= signed_div;
            sign_a_reg <= a[31];
            sign_b_reg <= b[31];
            bzero_reg  <= (b == 32'd0);
          end
        end
        RUN: begin
          if (cancel) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end else begin
            rem_reg   <= rem_next;
            quo_reg   <= quo_next;
            count_reg <= count_reg + 5'd1;
            if (count_reg == 5'd31) begin
              state_reg <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              result    <= result_next;
            end
          end
        end
        DONE: begin
          // Leaves DONE unconditionally; cancel here has nothing left to abort.
          state_reg <= IDLE;
          done      <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_radix2.sv
// Directed bench for div_radix2: expected results queued at start, checked at the done pulse.
module tb_div_radix2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [63:0] result;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] sb_q[$];
  logic [63:0] last_good = 64'd0;

  always #5 clk = ~clk;

  div_radix2 dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .a          (a),
    .b          (b),
    .cancel     (cancel),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  function automatic logic [63:0] model(input logic sd, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] q;
    logic [31:0] r;
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (sd && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    if (sd) begin
      q = $signed(x) / $signed(y);
      r = $signed(x) % $signed(y);
    end else begin
      q = x / y;
      r = x % y;
    end
    return {r, q};
  endfunction

  // Issue one divide, optionally pulsing start with junk operands while it runs.
  task automatic run_op(input string tag, input logic sd, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] want, input bit noise);
    int          cycles;
    int          busy_cnt;
    logic [63:0] exp_res;
    signed_div = sd;
    a          = x;
    b          = y;
    start      = 1'b1;
    sb_q.push_back(want);
    tick();
    cycles   = 1;
    busy_cnt = 0;
    while (done !== 1'b1 && cycles < 60) begin
      if (busy === 1'b1) busy_cnt++;
      if (noise) begin
        start      = (cycles % 4 == 0);
        signed_div = ~sd;
        a          = $urandom;
        b          = $urandom;
      end else begin
        start = 1'b0;
      end
      tick();
      cycles++;
    end
    start = 1'b0;
    if (done !== 1'b1) begin
      check({tag, " timeout"}, 64'(done), 64'd1);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end else begin
      check({tag, " latency"}, 64'(cycles), 64'd33);
      check({tag, " busy cycles"}, 64'(busy_cnt), 64'd32);
      check({tag, " busy at done"}, 64'(busy), 64'd0);
      if (sb_q.size() == 0) begin
        check({tag, " queue"}, 64'(sb_q.size()), 64'd1);
      end else begin
        exp_res = sb_q.pop_front();
        check({tag, " result"}, result, exp_res);
        last_good = exp_res;
      end
    end
    tick();
    check({tag, " done pulse"}, 64'(done), 64'd0);
    check({tag, " idle after"}, 64'(busy), 64'd0);
    $display("op %s sd=%0d a=%h b=%h result=%h", tag, sd, x, y, result);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          done_seen;
    logic [31:0] rx;
    logic [31:0] ry;
    logic        rsd;

    rst        = 1'b1;
    start      = 1'b0;
    cancel     = 1'b0;
    signed_div = 1'b0;
    a          = 32'd0;
    b          = 32'd0;
    tick();
    tick();
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset result", result, 64'd0);
    rst = 1'b0;
    tick();

    run_op("udiv 100/7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0);
    run_op("sdiv -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
    run_op("sdiv 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 1'b0);
    run_op("sdiv overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 1'b0);
    run_op("udiv max/16", 1'b0, 32'hFFFF_FFFF, 32'h10, 64'h0000000F_0FFFFFFF, 1'b0);
    run_op("udiv 5/0", 1'b0, 32'd5, 32'd0, 64'h00000005_FFFFFFFF, 1'b0);
    run_op("sdiv 5/0", 1'b1, 32'd5, 32'd0, 64'h00000005_FFFFFFFF, 1'b0);
    run_op("sdiv -16/0", 1'b1, 32'hFFFF_FFF0, 32'd0, 64'hFFFFFFF0_FFFFFFFF, 1'b0);
    run_op("sdiv min/1", 1'b1, 32'h8000_0000, 32'd1, 64'h00000000_80000000, 1'b0);

    for (int i = 0; i < 6; i++) begin
      rsd = i[0];
      rx  = $urandom;
      ry  = $urandom >> $urandom_range(0, 28);
      if (ry == 32'd0) ry = 32'd3;
      run_op("random", rsd, rx, ry, model(rsd, rx, ry), 1'b0);
    end

    run_op("start ignored", 1'b0, 32'd1000, 32'd33, 64'h0000000A_0000001E, 1'b1);

    // Cancel on iteration 10.
    signed_div = 1'b0;
    a          = 32'd100;
    b          = 32'd7;
    start      = 1'b1;
    tick();
    start = 1'b0;
    check("cancel running", 64'(busy), 64'd1);
    repeat (10) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel busy", 64'(busy), 64'd0);
    check("cancel done", 64'(done), 64'd0);
    check("cancel result kept", result, last_good);
    done_seen = 0;
    repeat (40) begin
      tick();
      if (done === 1'b1) done_seen++;
    end
    check("cancel no done", 64'(done_seen), 64'd0);
    $display("op cancel at iteration 10 result=%h", result);
    run_op("after cancel", 1'b1, 32'hFFFF_FF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 1'b0);

    // start and cancel together in IDLE: start is dropped.
    start  = 1'b1;
    cancel = 1'b1;
    tick();
    start  = 1'b0;
    cancel = 1'b0;
    check("start+cancel busy", 64'(busy), 64'd0);
    repeat (3) tick();
    check("start+cancel stays idle", 64'(busy), 64'd0);
    check("start+cancel no done", 64'(done), 64'd0);
    $display("op start+cancel in idle busy=%0d", busy);

    // Reset on iteration 20.
    signed_div = 1'b0;
    a          = 32'd100;
    b          = 32'd7;
    start      = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrun reset busy", 64'(busy), 64'd0);
    check("midrun reset done", 64'(done), 64'd0);
    check("midrun reset result", result, 64'd0);
    $display("op reset at iteration 20 result=%h", result);
    last_good = 64'd0;
    tick();
    run_op("after reset 100/7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
